// File: rtl/fxp_mul_seq_if.sv
// Start/Busy/Done handshake and operand/result bundle for the sequential fixed-point multiplier.
// The master drives the request and operands; the slave returns status and the registered result.
interface fxp_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] intpart;
  logic [WIDTH-1:0] fracpart;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             overflow;
  logic             zero;

  modport master (
    output start, intpart, fracpart, divisor,
    input  busy, done, out1, out2, overflow, zero
  );

  modport slave (
    input  start, intpart, fracpart, divisor,
    output busy, done, out1, out2, overflow, zero
  );
endinterface

// File: rtl/fxp_mul_seq.sv
// Radix-2 shift-add multiplier rebuilding a dividend from a 16.16 quotient and its divisor.
// Fixed latency of WIDTH+1 cycles from the accepting edge; results hold until the next completion.
module fxp_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  fxp_mul_seq_if.slave  bus
);

  localparam int PW = 3 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            cnt_last;

  function automatic logic ovf_flag(input logic [PW-1:0] p);
    return |p[PW-1:2*WIDTH];
  endfunction

  function automatic logic zero_flag(input logic [PW-1:0] p);
    return (p[2*WIDTH-1:0] == '0);
  endfunction

  assign cnt_last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt_last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.out1     <= '0;
      bus.out2     <= '0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b1;
    end else begin
      state    <= state_nxt;
      bus.busy <= (state_nxt == RUN);
      bus.done <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH{1'b0}}, bus.intpart, bus.fracpart};
            mplier <= bus.divisor;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        // one divisor bit per cycle; the loop never exits early on a zero divisor
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          bus.out1     <= acc[2*WIDTH-1:WIDTH];
          bus.out2     <= acc[WIDTH-1:0];
          bus.overflow <= ovf_flag(acc);
          bus.zero     <= zero_flag(acc);
        end
        default: ;
      endcase
    end
  end

endmodule
